// File: rtl/btn_pkg.sv
// Shared event codes and FSM encodings for the button event unit.
package btn_pkg;

    localparam logic [2:0] EV_NONE         = 3'd0;
    localparam logic [2:0] EV_PRESS        = 3'd1;
    localparam logic [2:0] EV_RELEASE      = 3'd2;
    localparam logic [2:0] EV_LONG         = 3'd3;
    localparam logic [2:0] EV_REPEAT       = 3'd4;
    localparam logic [2:0] EV_RELEASE_LONG = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_REP  = 2'd2;

endpackage

// File: rtl/btn_evt_slot.sv
// One-deep event register with valid/ack handshake and sticky drop flag.
module btn_evt_slot
    import btn_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic       emit_i,
    input  logic [2:0] code_i,
    input  logic       ack_i,
    input  logic       ovf_clr_i,
    output logic       valid_o,
    output logic [2:0] code_o,
    output logic       ovf_o
);

    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;
    logic       ovf_q, ovf_d;
    logic       consume;
    logic       drop;

    assign consume = valid_q & ack_i;
    assign drop    = emit_i & valid_q & ~consume;

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        if (emit_i && (!valid_q || consume)) begin
            valid_d = 1'b1;
            code_d  = code_i;
        end else if (consume && !emit_i) begin
            valid_d = 1'b0;
            code_d  = EV_NONE;
        end
        // A drop in the same cycle as a clear keeps the flag set
        ovf_d = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            valid_q <= 1'b0;
            code_q  <= EV_NONE;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign code_o  = code_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/btn_event.sv
// Turns a debounced button level into press/release/long/repeat events.
module btn_event
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 26
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       btn_db,
    input  logic       event_ack,
    input  logic       ovf_clr,
    output logic       event_valid,
    output logic [2:0] event_code,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       held,
    output logic       ovf
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, armed_q;
    logic             press_q, release_q, held_q;
    logic             rise, fall;
    logic             emit;
    logic [2:0]       code;

    // Edges are suppressed until armed so a button held through reset is ignored
    assign rise = armed_q & btn_db & ~btn_q;
    assign fall = armed_q & ~btn_db & btn_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        code    = EV_NONE;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    emit    = 1'b1;
                    code    = EV_PRESS;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    emit    = 1'b1;
                    code    = EV_RELEASE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_REP;
                    cnt_d   = '0;
                    emit    = 1'b1;
                    code    = EV_LONG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    emit    = 1'b1;
                    code    = EV_RELEASE_LONG;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    emit  = REPEAT_EN;
                    code  = REPEAT_EN ? EV_REPEAT : EV_NONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_db;
            armed_q   <= 1'b1;
            press_q   <= emit && (code == EV_PRESS);
            release_q <= emit && ((code == EV_RELEASE) ||
                                  (code == EV_RELEASE_LONG));
            held_q    <= (state_d != ST_IDLE);
        end
    end

    btn_evt_slot u_slot (
        .clk       (clk),
        .n_reset   (n_reset),
        .emit_i    (emit),
        .code_i    (code),
        .ack_i     (event_ack),
        .ovf_clr_i (ovf_clr),
        .valid_o   (event_valid),
        .code_o    (event_code),
        .ovf_o     (ovf)
    );

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign held          = held_q;

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event: event timing, handshake, overflow, reset.
module tb_btn_event;
    import btn_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       btn_db = 1'b0;
    logic       event_ack = 1'b1;
    logic       ovf_clr = 1'b0;

    logic       valid1, press1, rel1, held1, ovf1;
    logic [2:0] code1;
    logic       valid2, press2, rel2, held2, ovf2;
    logic [2:0] code2;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    ev_t exp1[$];
    ev_t obs1[$];
    ev_t exp2[$];
    ev_t obs2[$];

    btn_event #(
        .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1), .CNT_W(4)
    ) dut (
        .clk(clk), .n_reset(n_reset), .btn_db(btn_db),
        .event_ack(event_ack), .ovf_clr(ovf_clr),
        .event_valid(valid1), .event_code(code1),
        .press_pulse(press1), .release_pulse(rel1),
        .held(held1), .ovf(ovf1)
    );

    btn_event #(
        .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b0), .CNT_W(4)
    ) dut_norep (
        .clk(clk), .n_reset(n_reset), .btn_db(btn_db),
        .event_ack(event_ack), .ovf_clr(ovf_clr),
        .event_valid(valid2), .event_code(code2),
        .press_pulse(press2), .release_pulse(rel2),
        .held(held2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // With ack high, every valid cycle is one distinct consumed event
    always @(negedge clk) begin
        #1;
        if (valid1 && event_ack) obs1.push_back('{cyc, code1});
        if (valid2 && event_ack) obs2.push_back('{cyc, code2});
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic press_for(input int n, output int t);
        @(negedge clk);
        btn_db = 1'b1;
        t = cyc + 1;
        repeat (n) @(negedge clk);
        btn_db = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({valid1, code1, press1, rel1, held1, ovf1} !== 8'd0)
            $display("FAIL reset_out1 got %b want 0",
                     {valid1, code1, press1, rel1, held1, ovf1});
        else pass_cnt++;
        total_cnt++;
        if ({valid2, code2, press2, rel2, held2, ovf2} !== 8'd0)
            $display("FAIL reset_out2 got %b want 0",
                     {valid2, code2, press2, rel2, held2, ovf2});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_short();
        int t;
        ev_t e, o;
        exp1.delete();
        obs1.delete();
        press_for(3, t);
        exp1.push_back('{t, EV_PRESS});
        exp1.push_back('{t + 3, EV_RELEASE});
        @(negedge clk);
        total_cnt++;
        if (rel1 !== 1'b1) $display("FAIL short_relpulse got %b want 1", rel1);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            total_cnt++;
            if (obs1.size() == 0)
                $display("FAIL short_ev missing cyc %0d code %0d", e.cyc, e.code);
            else begin
                o = obs1.pop_front();
                if (o.cyc !== e.cyc || o.code !== e.code)
                    $display("FAIL short_ev got %0d@%0d want %0d@%0d",
                             o.code, o.cyc, e.code, e.cyc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs1.size() != 0) $display("FAIL short_extra got %0d want 0", obs1.size());
        else pass_cnt++;
        total_cnt++;
        if (ovf1 !== 1'b0) $display("FAIL short_ovf got %b want 0", ovf1);
        else pass_cnt++;
    endtask

    task automatic test_long_repeat();
        int t;
        ev_t e, o;
        exp1.delete();
        obs1.delete();
        press_for(20, t);
        exp1.push_back('{t, EV_PRESS});
        exp1.push_back('{t + 8, EV_LONG});
        exp1.push_back('{t + 12, EV_REPEAT});
        exp1.push_back('{t + 16, EV_REPEAT});
        exp1.push_back('{t + 20, EV_RELEASE_LONG});
        repeat (4) @(negedge clk);
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            total_cnt++;
            if (obs1.size() == 0)
                $display("FAIL long_ev missing cyc %0d code %0d", e.cyc, e.code);
            else begin
                o = obs1.pop_front();
                if (o.cyc !== e.cyc || o.code !== e.code)
                    $display("FAIL long_ev got %0d@%0d want %0d@%0d",
                             o.code, o.cyc, e.code, e.cyc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs1.size() != 0) $display("FAIL long_extra got %0d want 0", obs1.size());
        else pass_cnt++;
    endtask

    task automatic test_norepeat();
        int t;
        int bad;
        ev_t e, o;
        exp2.delete();
        obs2.delete();
        bad = 0;
        @(negedge clk);
        btn_db = 1'b1;
        t = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (held2 !== 1'b1) bad++;
        end
        btn_db = 1'b0;
        total_cnt++;
        if (bad != 0) $display("FAIL norep_held got %0d low cycles want 0", bad);
        else pass_cnt++;
        exp2.push_back('{t, EV_PRESS});
        exp2.push_back('{t + 8, EV_LONG});
        exp2.push_back('{t + 20, EV_RELEASE_LONG});
        repeat (4) @(negedge clk);
        while (exp2.size() > 0) begin
            e = exp2.pop_front();
            total_cnt++;
            if (obs2.size() == 0)
                $display("FAIL norep_ev missing cyc %0d code %0d", e.cyc, e.code);
            else begin
                o = obs2.pop_front();
                if (o.cyc !== e.cyc || o.code !== e.code)
                    $display("FAIL norep_ev got %0d@%0d want %0d@%0d",
                             o.code, o.cyc, e.code, e.cyc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs2.size() != 0) $display("FAIL norep_extra got %0d want 0", obs2.size());
        else pass_cnt++;
        total_cnt++;
        if (held2 !== 1'b0) $display("FAIL norep_held_end got %b want 0", held2);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int t;
        @(negedge clk);
        event_ack = 1'b0;
        press_for(3, t);
        @(negedge clk);
        total_cnt++;
        if (valid1 !== 1'b1 || code1 !== EV_PRESS)
            $display("FAIL ovf_pending got %b/%0d want 1/%0d", valid1, code1, EV_PRESS);
        else pass_cnt++;
        total_cnt++;
        if (ovf1 !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf1);
        else pass_cnt++;
        total_cnt++;
        if (rel1 !== 1'b1) $display("FAIL ovf_relpulse got %b want 1", rel1);
        else pass_cnt++;
        event_ack = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (valid1 !== 1'b0 || code1 !== EV_NONE)
            $display("FAIL ovf_consume got %b/%0d want 0/0", valid1, code1);
        else pass_cnt++;
        total_cnt++;
        if (ovf1 !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf1);
        else pass_cnt++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total_cnt++;
        if (ovf1 !== 1'b0) $display("FAIL ovf_clr got %b want 0", ovf1);
        else pass_cnt++;
        obs1.delete();
        obs2.delete();
    endtask

    task automatic test_held_through_reset();
        int t;
        ev_t e, o;
        exp1.delete();
        @(negedge clk);
        n_reset = 1'b0;
        btn_db = 1'b1;
        repeat (2) @(negedge clk);
        obs1.delete();
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (obs1.size() != 0 || held1 !== 1'b0)
            $display("FAIL rst_held got %0d ev held %b want 0 ev held 0",
                     obs1.size(), held1);
        else pass_cnt++;
        btn_db = 1'b0;
        repeat (2) @(negedge clk);
        press_for(3, t);
        exp1.push_back('{t, EV_PRESS});
        exp1.push_back('{t + 3, EV_RELEASE});
        repeat (4) @(negedge clk);
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            total_cnt++;
            if (obs1.size() == 0)
                $display("FAIL rst_ev missing cyc %0d code %0d", e.cyc, e.code);
            else begin
                o = obs1.pop_front();
                if (o.cyc !== e.cyc || o.code !== e.code)
                    $display("FAIL rst_ev got %0d@%0d want %0d@%0d",
                             o.code, o.cyc, e.code, e.cyc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs1.size() != 0) $display("FAIL rst_extra got %0d want 0", obs1.size());
        else pass_cnt++;
    endtask

    task automatic test_fall_vs_long();
        int t;
        ev_t e, o;
        exp1.delete();
        obs1.delete();
        press_for(8, t);
        exp1.push_back('{t, EV_PRESS});
        exp1.push_back('{t + 8, EV_RELEASE});
        repeat (4) @(negedge clk);
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            total_cnt++;
            if (obs1.size() == 0)
                $display("FAIL edge_ev missing cyc %0d code %0d", e.cyc, e.code);
            else begin
                o = obs1.pop_front();
                if (o.cyc !== e.cyc || o.code !== e.code)
                    $display("FAIL edge_ev got %0d@%0d want %0d@%0d",
                             o.code, o.cyc, e.code, e.cyc);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs1.size() != 0) $display("FAIL edge_extra got %0d want 0", obs1.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_rep();
        int t;
        ev_t e, o;
        exp1.delete();
        obs1.delete();
        @(negedge clk);
        btn_db = 1'b1;
        t = cyc + 1;
        repeat (13) @(negedge clk);
        total_cnt++;
        if (valid1 !== 1'b1 || code1 !== EV_REPEAT || held1 !== 1'b1)
            $display("FAIL midrep_pre got %b/%0d/%b want 1/%0d/1",
                     valid1, code1, held1, EV_REPEAT);
        else pass_cnt++;
        #2;
        n_reset = 1'b0;
        #1;
        total_cnt++;
        if ({valid1, code1, press1, rel1, held1, ovf1} !== 8'd0)
            $display("FAIL midrep_async got %b want 0",
                     {valid1, code1, press1, rel1, held1, ovf1});
        else pass_cnt++;
        exp1.push_back('{t, EV_PRESS});
        exp1.push_back('{t + 8, EV_LONG});
        exp1.push_back('{t + 12, EV_REPEAT});
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            total_cnt++;
            if (obs1.size() == 0)
                $display("FAIL midrep_ev missing cyc %0d code %0d", e.cyc, e.code);
            else begin
                o = obs1.pop_front();
                if (o.cyc !== e.cyc || o.code !== e.code)
                    $display("FAIL midrep_ev got %0d@%0d want %0d@%0d",
                             o.code, o.cyc, e.code, e.cyc);
                else pass_cnt++;
            end
        end
        @(negedge clk);
        obs1.delete();
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
        btn_db = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (obs1.size() != 0) $display("FAIL midrep_norel got %0d ev want 0", obs1.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_short();
        test_long_repeat();
        test_norepeat();
        test_overflow();
        test_held_through_reset();
        test_fall_vs_long();
        test_reset_mid_rep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
